// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller slice.
//   state_e         : handshake FSM state (3 is unused and recovers to IDLE)
//   VEC_BASE_DEF    : default handler address of source 0
//   VEC_STRIDE_DEF  : default address distance between consecutive handlers
package irq_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    localparam logic [9:0]  VEC_BASE_DEF   = 10'h3C0;
    localparam int unsigned VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake bundle.
//   int_req    : controller -> CPU, request pending service
//   int_id     : controller -> CPU, index of requested / in-service source
//   int_vector : controller -> CPU, handler address for int_id
//   int_ack    : CPU -> controller, request accepted
//   int_done   : CPU -> controller, return from interrupt
// master = controller side, slave = CPU side.
interface irq_controller_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned VEC_W = 10
);
    import irq_controller_pkg::*;

    localparam int unsigned IDW = $clog2(WIDTH);

    logic             int_req;
    logic [IDW-1:0]   int_id;
    logic [VEC_W-1:0] int_vector;
    logic             int_ack;
    logic             int_done;

    modport master (
        output int_req, int_id, int_vector,
        input  int_ack, int_done
    );

    modport slave (
        input  int_req, int_id, int_vector,
        output int_ack, int_done
    );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Highest-set-bit encoder.
//   req_i   : request vector, higher index = higher priority
//   idx_o   : index of the highest set bit (0 when none set)
//   valid_o : at least one bit of req_i is set
module irq_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDW-1:0]   idx_o,
    output logic             valid_o
);

    // Ascending scan: the last hit is the highest index.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req_i[i]) idx_o = IDW'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches request pulses into pending bits, gates them
// with a software mask, and hands the highest-priority enabled source to the
// CPU through a req/ack/done handshake. One interrupt in service at a time.
//   clk, reset  : clock, asynchronous active-high reset
//   irq_in      : one-cycle request pulses, one bit per source
//   mask_we     : mask write enable, mask_wdata: new mask value
//   mask_q      : current mask (1 = enabled)
//   pending_q   : latched pending bits
//   ovf_q       : sticky lost-event flags, ovf_clr clears them
//   bus         : CPU handshake (int_req/int_id/int_vector/int_ack/int_done)
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
    parameter int unsigned      VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [WIDTH-1:0] MASK_INIT  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     irq_in,
    input  logic                 mask_we,
    input  logic [WIDTH-1:0]     mask_wdata,
    output logic [WIDTH-1:0]     mask_q,
    output logic [WIDTH-1:0]     pending_q,
    output logic [WIDTH-1:0]     ovf_q,
    input  logic                 ovf_clr,
    irq_controller_if.master     bus
);

    localparam int unsigned IDW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             int_req_q, int_req_d;
    logic [IDW-1:0]   int_id_q, int_id_d;
    logic [WIDTH-1:0] clr_onehot;
    logic [WIDTH-1:0] pending_d, ovf_d, mask_d;
    logic [IDW-1:0]   sel_id;
    logic             sel_valid;

    irq_prio_enc #(
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) u_prio_enc (
        .req_i   (pending_q & mask_q),
        .idx_o   (sel_id),
        .valid_o (sel_valid)
    );

    // Pending / overflow / mask next state. A new pulse wins over the ack
    // clear; an event only overflows if its bit stays pending this cycle.
    always_comb begin
        pending_d = (pending_q & ~clr_onehot) | irq_in;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (irq_in & pending_q & ~clr_onehot);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            mask_q    <= MASK_INIT;
        end else begin
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            mask_q    <= mask_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sel_valid)    state_d = ST_REQ;
            ST_REQ:  if (bus.int_ack)  state_d = ST_SVC;
            ST_SVC:  if (bus.int_done) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the ack clear.
    always_comb begin
        clr_onehot = '0;
        int_id_d   = int_id_q;
        int_req_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    int_id_d  = sel_id;
                    int_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) clr_onehot = WIDTH'(1) << int_id_q;
                else             int_req_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.int_vector = VEC_BASE + VEC_W'(int_id_q) * VEC_W'(VEC_STRIDE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations checked at
// #1 after each rising edge; inputs are driven at the same point.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask_q;
    logic [7:0] pending_q;
    logic [7:0] ovf_q;
    logic       ovf_clr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    irq_controller_if #(.WIDTH(8), .VEC_W(10)) bus ();

    irq_controller #(
        .WIDTH      (8),
        .VEC_W      (10),
        .VEC_BASE   (10'h3C0),
        .VEC_STRIDE (4),
        .MASK_INIT  (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .ovf_q      (ovf_q),
        .ovf_clr    (ovf_clr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        irq_in       = '0;
        mask_we      = 1'b0;
        mask_wdata   = '0;
        ovf_clr      = 1'b0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        tick();
        tick();
        check("rst_pending", pending_q, 8'h00);
        check("rst_ovf", ovf_q, 8'h00);
        check("rst_mask", mask_q, 8'h00);
        check("rst_req", bus.int_req, 1'b0);
        check("rst_id", bus.int_id, 3'd0);
        check("rst_vec", bus.int_vector, 10'h3C0);
        reset = 1'b0;
        tick();

        // 1: single source 7
        write_mask(8'h80);
        check("t1_mask", mask_q, 8'h80);
        irq_in = 8'h80; tick(); irq_in = '0;
        check("t1_pend", pending_q, 8'h80);
        check("t1_req_early", bus.int_req, 1'b0);
        tick();
        check("t1_req", bus.int_req, 1'b1);
        check("t1_id", bus.int_id, 3'd7);
        check("t1_vec", bus.int_vector, 10'h3DC);
        tick();
        check("t1_req_hold", bus.int_req, 1'b1);
        pulse_ack();
        check("t1_pend_clr", pending_q, 8'h00);
        check("t1_req_drop", bus.int_req, 1'b0);
        pulse_done();

        // 2: two simultaneous sources, priority then follow-up
        write_mask(8'hFF);
        irq_in = 8'h05; tick(); irq_in = '0;
        check("t2_pend", pending_q, 8'h05);
        tick();
        check("t2_req", bus.int_req, 1'b1);
        check("t2_id", bus.int_id, 3'd2);
        check("t2_vec", bus.int_vector, 10'h3C8);
        pulse_ack();
        check("t2_pend_ack", pending_q, 8'h01);
        tick();
        check("t2_svc_req", bus.int_req, 1'b0);
        check("t2_svc_id", bus.int_id, 3'd2);
        pulse_done();
        check("t2_idle_req", bus.int_req, 1'b0);
        tick();
        check("t2_req2", bus.int_req, 1'b1);
        check("t2_id2", bus.int_id, 3'd0);
        check("t2_vec2", bus.int_vector, 10'h3C0);
        pulse_ack();
        pulse_done();

        // 3: masked source latches, enabled later
        write_mask(8'h00);
        irq_in = 8'h10; tick(); irq_in = '0;
        check("t3_pend", pending_q, 8'h10);
        tick(); tick();
        check("t3_masked", bus.int_req, 1'b0);
        write_mask(8'h10);
        check("t3_w1", bus.int_req, 1'b0);
        tick();
        check("t3_req", bus.int_req, 1'b1);
        check("t3_id", bus.int_id, 3'd4);
        pulse_ack();
        pulse_done();

        // 4: committed selection, ack+done together
        write_mask(8'hFF);
        irq_in = 8'h08; tick(); irq_in = '0;
        tick();
        check("t4_id", bus.int_id, 3'd3);
        irq_in = 8'h80; tick(); irq_in = '0;
        check("t4_id_hold", bus.int_id, 3'd3);
        check("t4_pend", pending_q, 8'h88);
        tick();
        check("t4_id_hold2", bus.int_id, 3'd3);
        bus.int_ack = 1'b1; bus.int_done = 1'b1; tick();
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        check("t4_ackdone_pend", pending_q, 8'h80);
        check("t4_ackdone_req", bus.int_req, 1'b0);
        tick();
        check("t4_still_svc", bus.int_req, 1'b0);
        pulse_done();
        tick();
        check("t4_req7", bus.int_req, 1'b1);
        check("t4_id7", bus.int_id, 3'd7);

        // 5: overflow on id 7 (still in REQUEST for 7)
        irq_in = 8'h80; tick(); irq_in = '0;
        check("t5_ovf", ovf_q, 8'h80);
        irq_in = 8'h80; ovf_clr = 1'b1; tick(); irq_in = '0; ovf_clr = 1'b0;
        check("t5_ovf_setwins", ovf_q, 8'h80);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t5_ovf_clr", ovf_q, 8'h00);
        irq_in = 8'h80; bus.int_ack = 1'b1; tick();
        irq_in = '0; bus.int_ack = 1'b0;
        check("t5_ack_pend", pending_q, 8'h80);
        check("t5_ack_ovf", ovf_q, 8'h00);
        check("t5_ack_req", bus.int_req, 1'b0);
        pulse_done();
        tick();
        check("t5_req7_again", bus.int_req, 1'b1);
        pulse_ack();
        pulse_done();
        check("t5_pend_empty", pending_q, 8'h00);

        // 6: reset in SERVICE
        irq_in = 8'h22; tick(); irq_in = '0;
        tick();
        check("t6_id", bus.int_id, 3'd5);
        irq_in = 8'h20; pulse_ack(); irq_in = '0;
        check("t6_pend", pending_q, 8'h22);
        check("t6_ovf", ovf_q, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_pend", pending_q, 8'h00);
        check("t6_rst_mask", mask_q, 8'h00);
        check("t6_rst_req", bus.int_req, 1'b0);
        check("t6_rst_id", bus.int_id, 3'd0);
        check("t6_rst_vec", bus.int_vector, 10'h3C0);
        tick();
        reset = 1'b0;
        write_mask(8'hFF);
        pulse_done();
        tick();
        check("t6_done_ignored", bus.int_req, 1'b0);
        check("t6_pend_after", pending_q, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Interrupt controller that consumes the periodic request vector produced by the timer and by other peripheral sources, one bit per source. It latches single-cycle request pulses into pending bits, applies a software-writable mask, and selects the highest-priority enabled source. It presents that source to the single-cycle CPU through a request/acknowledge/done handshake, together with the handler vector address. Nesting is not supported: one interrupt is in service at a time.

Parameters:
WIDTH, 8, number of interrupt lines; bit i is source i, and a higher index has higher priority.
VEC_W, 10, width of the handler vector address.
VEC_BASE, 10'h3C0, handler address of source 0.
VEC_STRIDE, 4, address distance between consecutive handlers.
MASK_INIT, 0, mask value loaded on reset; bit = 1 means the source is enabled.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
irq_in  in  WIDTH  request pulses, one cycle wide per event (timer drives MSB)
mask_we  in  1  write enable for the mask register
mask_wdata  in  WIDTH  new mask value
mask_q  out  WIDTH  current mask
pending_q  out  WIDTH  latched pending bits
ovf_q  out  WIDTH  sticky lost-event flags
ovf_clr  in  1  clears all ovf_q bits
int_req  out  1  interrupt request to the CPU
int_id  out  $clog2(WIDTH)  index of the requested or in-service source
int_vector  out  VEC_W  VEC_BASE + int_id*VEC_STRIDE, truncated to VEC_W
int_ack  in  1  CPU accepts the request (jumps to the vector)
int_done  in  1  CPU signals return from interrupt

Behaviour:
- Reset (async): pending_q=0, ovf_q=0, mask_q=MASK_INIT, state=IDLE, int_req=0, int_id=0, int_vector=VEC_BASE.
- Pending latch, every cycle: pending <= (pending & ~clr_onehot) | irq_in.
  - A set wins over a clear on the same bit in the same cycle.
  - Masked sources still latch pending; the mask only gates selection.
- Overflow: ovf[i] <= ovf[i] | (irq_in[i] & pending[i] & ~clr_onehot[i]).
  - ovf_clr clears all bits; a set in the same cycle wins.
- Mask: mask_q <= mask_wdata when mask_we=1. The new value is used for selection from the next cycle.
- FSM, three states, registered outputs.
  - IDLE: int_req=0.
    - If (pending & mask) != 0: latch int_id = index of the highest set bit; go to REQUEST.
    - int_ack and int_done are ignored.
  - REQUEST: int_req=1; int_id and int_vector are held stable.
    - The selection is committed: a later mask change or a higher-priority arrival does not alter it.
    - On int_ack=1: clr_onehot = 1<<int_id for that cycle; go to SERVICE.
    - int_done is ignored.
  - SERVICE: int_req=0; int_id is held.
    - On int_done=1: go to IDLE. The next selection occurs in IDLE in the following cycle.
    - int_ack is ignored.
  - int_ack and int_done asserted together in REQUEST: the ack is taken and the done is ignored.
- Latency:
  - An irq_in pulse in cycle n appears in pending_q at n+1.
  - From IDLE, int_req is asserted at n+2.
  - After int_done in cycle m, FSM is IDLE at m+1; if another enabled source is pending, int_req is asserted at m+2.
- clr_onehot is 0 in every cycle except the ack cycle in REQUEST.
- Reset mid-handshake returns to IDLE immediately and drops all pending events.
- int_vector is computed combinationally from the registered int_id, so it is stable whenever int_id is.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_REQ=2'd1, ST_SVC=2'd2; encoding 2'd3 returns to IDLE;
  - default VEC_BASE and VEC_STRIDE constants.
- One sub-module, irq_prio_enc: a parameterised WIDTH to $clog2(WIDTH) highest-set-bit encoder with a valid output.

Test Plan:
1. Reset, then mask=8'h80 and irq_in=8'h80 pulsed at cycle 10 -> pending_q=8'h80 at 11, int_req=1 at 12, int_id=7, int_vector=10'h3DC; ack at 14 -> pending_q=0 at 15, int_req=0.
2. mask=8'hFF, irq_in=8'h05 in one cycle -> int_id=2 first; after ack and done, int_id=0 is requested 2 cycles after the done.
3. mask=8'h00, irq_in=8'h10 -> pending_q=8'h10 and int_req stays 0; write mask=8'h10 -> int_req=1 two cycles after the write cycle.
4. In REQUEST for id 3, irq_in=8'h80 arrives -> int_id stays 3 until ack; id 7 is requested after the done.
5. pending[7]=1 and a second irq_in[7] pulse arrives -> ovf_q=8'h80; a pulse in the ack cycle for id 7 leaves pending[7]=1 and ovf_q[7] unchanged; ovf_clr -> ovf_q=0.
6. Reset asserted in SERVICE with pending=8'h22 -> all outputs take reset values immediately; int_done afterwards is ignored.
